// File: rtl/consmax_pack.sv
// consmax_pack: packs a stream of signed ConSmax elements into LANE_NUM-wide
// words, framed by a configurable row length. Completed words go through a
// small output FIFO with a valid/ready handshake. There is no backpressure
// toward the element source: a word that completes while the FIFO is full
// (and not popping in the same cycle) is dropped and the sticky ovf_err flag
// is raised. Row framing is kept intact across drops.
//
// Optional feature: define CONSMAX_PACK_SUM_EN to add a per-row signed sum
// output (row_sum / row_sum_valid). Without the macro those ports and the
// accumulator are absent and all other behaviour is identical.
//
// FIFO head fields are registered: the output register is loaded with the
// post-edge head of the FIFO, so a word pushed into an empty FIFO is visible
// in the following cycle and the head holds steady while stalled.

module consmax_pack #(
    parameter int IDATA_BIT  = 8,
    parameter int LANE_NUM   = 8,
    parameter int ROW_BIT    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [ROW_BIT-1:0]            cfg_row_len,
    input  logic                          clr_err,
    input  logic [IDATA_BIT-1:0]          idata,
    input  logic                          idata_valid,
    output logic [LANE_NUM*IDATA_BIT-1:0] odata,
    output logic [LANE_NUM-1:0]           odata_mask,
    output logic                          odata_last,
    output logic                          odata_valid,
    input  logic                          odata_ready,
    output logic                          ovf_err
`ifdef CONSMAX_PACK_SUM_EN
    ,
    output logic [IDATA_BIT+ROW_BIT-1:0]  row_sum,
    output logic                          row_sum_valid
`endif
);

    localparam int WORD_W  = LANE_NUM * IDATA_BIT;
    localparam int ENTRY_W = WORD_W + LANE_NUM + 1;
    localparam int LANE_W  = (LANE_NUM > 1) ? $clog2(LANE_NUM) : 1;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [LANE_W-1:0]  lane_cnt_r;
    logic [ROW_BIT-1:0] elem_cnt_r;
    logic [ROW_BIT-1:0] row_len_r;
    logic [WORD_W-1:0]  asm_r;

    logic [ENTRY_W-1:0] fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]   count_r;

    logic [WORD_W-1:0]   odata_r;
    logic [LANE_NUM-1:0] odata_mask_r;
    logic                odata_last_r;
    logic                odata_valid_r;
    logic                ovf_err_r;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic                first_s;
    logic [ROW_BIT-1:0]  eff_len_s;
    logic                last_elem_s;
    logic                lane_full_s;
    logic                word_done_s;
    logic [WORD_W-1:0]   word_s;
    logic [LANE_NUM-1:0] mask_s;
    logic [ENTRY_W-1:0]  entry_s;
    logic                pop_s;
    logic                full_s;
    logic                push_s;
    logic                drop_s;
    logic [PTR_W-1:0]    rd_ptr_nxt_s;
    logic [PTR_W-1:0]    wr_ptr_nxt_s;
    logic [CNT_W-1:0]    count_nxt_s;
    logic [ENTRY_W-1:0]  head_nxt_s;

    // Pointer increment with explicit wrap so any depth works.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Row framing: effective row length, last-element and word-completion detection.
    always_comb begin
        first_s     = (elem_cnt_r == '0);
        eff_len_s   = row_len_r;
        if (first_s) begin
            if (cfg_row_len == '0) begin
                eff_len_s = ROW_BIT'(1);
            end else begin
                eff_len_s = cfg_row_len;
            end
        end else begin
            eff_len_s = row_len_r;
        end
        last_elem_s = idata_valid && (elem_cnt_r == (eff_len_s - ROW_BIT'(1)));
        lane_full_s = (lane_cnt_r == LANE_W'(LANE_NUM - 1));
        word_done_s = idata_valid && (lane_full_s || last_elem_s);
    end

    // Word assembly: merge the incoming element into its lane and build the lane mask.
    always_comb begin
        word_s = asm_r;
        mask_s = '0;
        for (int l = 0; l < LANE_NUM; l++) begin
            if (LANE_W'(l) == lane_cnt_r) begin
                word_s[l*IDATA_BIT +: IDATA_BIT] = idata;
            end else begin
                word_s[l*IDATA_BIT +: IDATA_BIT] = asm_r[l*IDATA_BIT +: IDATA_BIT];
            end
            if (LANE_W'(l) <= lane_cnt_r) begin
                mask_s[l] = 1'b1;
            end else begin
                mask_s[l] = 1'b0;
            end
        end
        entry_s = {last_elem_s, mask_s, word_s};
    end

    // FIFO control: push/pop/drop decisions and next-state pointers and head.
    always_comb begin
        pop_s        = odata_valid_r && odata_ready;
        full_s       = (count_r == CNT_W'(FIFO_DEPTH));
        push_s       = word_done_s && (!full_s || pop_s);
        drop_s       = word_done_s && !push_s;
        rd_ptr_nxt_s = rd_ptr_r;
        wr_ptr_nxt_s = wr_ptr_r;
        count_nxt_s  = count_r;
        if (pop_s) begin
            rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        if (push_s) begin
            wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
        // The new word becomes the head only when it lands where the read
        // pointer will point after this edge (i.e. FIFO otherwise empty).
        if (count_nxt_s == '0) begin
            head_nxt_s = '0;
        end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = entry_s;
        end else begin
            head_nxt_s = fifo_mem_r[rd_ptr_nxt_s];
        end
    end

    // Lane/element counters, row-length latch and partial-word register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lane_cnt_r <= '0;
            elem_cnt_r <= '0;
            row_len_r  <= '0;
            asm_r      <= '0;
        end else if (idata_valid) begin
            if (first_s) begin
                row_len_r <= eff_len_s;
            end
            if (last_elem_s) begin
                elem_cnt_r <= '0;
            end else begin
                elem_cnt_r <= elem_cnt_r + ROW_BIT'(1);
            end
            if (word_done_s) begin
                lane_cnt_r <= '0;
                asm_r      <= '0;
            end else begin
                lane_cnt_r <= lane_cnt_r + LANE_W'(1);
                asm_r      <= word_s;
            end
        end
    end

    // FIFO storage; contents need no reset since validity comes from the count.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= entry_s;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            rd_ptr_r <= rd_ptr_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            count_r  <= count_nxt_s;
        end
    end

    // Registered head-of-FIFO outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            odata_r       <= '0;
            odata_mask_r  <= '0;
            odata_last_r  <= 1'b0;
            odata_valid_r <= 1'b0;
        end else begin
            odata_last_r  <= head_nxt_s[ENTRY_W-1];
            odata_mask_r  <= head_nxt_s[WORD_W +: LANE_NUM];
            odata_r       <= head_nxt_s[WORD_W-1:0];
            odata_valid_r <= (count_nxt_s != '0);
        end
    end

    // Sticky drop flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_err_r <= 1'b0;
        end else if (drop_s) begin
            ovf_err_r <= 1'b1;
        end else if (clr_err) begin
            ovf_err_r <= 1'b0;
        end
    end

    assign odata       = odata_r;
    assign odata_mask  = odata_mask_r;
    assign odata_last  = odata_last_r;
    assign odata_valid = odata_valid_r;
    assign ovf_err     = ovf_err_r;

`ifdef CONSMAX_PACK_SUM_EN
    localparam int SUM_W = IDATA_BIT + ROW_BIT;

    logic [SUM_W-1:0] sum_acc_r;
    logic [SUM_W-1:0] row_sum_r;
    logic             row_sum_valid_r;
    logic [SUM_W-1:0] elem_ext_s;
    logic [SUM_W-1:0] acc_in_s;

    // Sign-extend the element and add it to the running row sum.
    always_comb begin
        elem_ext_s = {{ROW_BIT{idata[IDATA_BIT-1]}}, idata};
        if (first_s) begin
            acc_in_s = elem_ext_s;
        end else begin
            acc_in_s = sum_acc_r + elem_ext_s;
        end
    end

    // Row accumulator; publishes the sum with a one-cycle pulse at row end, regardless of FIFO drops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum_acc_r       <= '0;
            row_sum_r       <= '0;
            row_sum_valid_r <= 1'b0;
        end else if (last_elem_s) begin
            sum_acc_r       <= '0;
            row_sum_r       <= acc_in_s;
            row_sum_valid_r <= 1'b1;
        end else begin
            row_sum_valid_r <= 1'b0;
            if (idata_valid) begin
                sum_acc_r <= acc_in_s;
            end
        end
    end

    assign row_sum       = row_sum_r;
    assign row_sum_valid = row_sum_valid_r;
`endif

endmodule

// File: tb/tb_consmax_pack.sv
// Directed self-checking bench for consmax_pack (default parameters).
// Row-sum checks are compiled in only when CONSMAX_PACK_SUM_EN is defined.
module tb_consmax_pack;

    logic        clk;
    logic        rstn;
    logic [7:0]  cfg_row_len;
    logic        clr_err;
    logic [7:0]  idata;
    logic        idata_valid;
    logic [63:0] odata;
    logic [7:0]  odata_mask;
    logic        odata_last;
    logic        odata_valid;
    logic        odata_ready;
    logic        ovf_err;
`ifdef CONSMAX_PACK_SUM_EN
    logic [15:0] row_sum;
    logic        row_sum_valid;
`endif

    int checks;
    int failures;

    consmax_pack dut (
        .clk         (clk),
        .rstn        (rstn),
        .cfg_row_len (cfg_row_len),
        .clr_err     (clr_err),
        .idata       (idata),
        .idata_valid (idata_valid),
        .odata       (odata),
        .odata_mask  (odata_mask),
        .odata_last  (odata_last),
        .odata_valid (odata_valid),
        .odata_ready (odata_ready),
        .ovf_err     (ovf_err)
`ifdef CONSMAX_PACK_SUM_EN
        ,
        .row_sum       (row_sum),
        .row_sum_valid (row_sum_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One element, accepted on the next rising edge; returns 1 time unit after it.
    task automatic send(input logic [7:0] v);
        idata       = v;
        idata_valid = 1'b1;
        @(posedge clk);
        #1;
        idata_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop();
        odata_ready = 1'b1;
        @(posedge clk);
        #1;
        odata_ready = 1'b0;
    endtask

    // Row r of the overflow test holds bytes r1..r8 (hex), lane 0 = r1.
    function automatic logic [63:0] row_word(input int r);
        logic [63:0] w;
        w = 64'h0;
        for (int i = 0; i < 8; i++) begin
            w[i*8 +: 8] = 8'((r * 16) + i + 1);
        end
        return w;
    endfunction

    initial begin
        checks      = 0;
        failures    = 0;
        rstn        = 1'b0;
        cfg_row_len = 8'd8;
        clr_err     = 1'b0;
        idata       = 8'h00;
        idata_valid = 1'b0;
        odata_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_valid", 128'(odata_valid), 128'(1'b0));
        chk("rst_data",  128'(odata), 128'(64'h0));
        chk("rst_mask",  128'(odata_mask), 128'(8'h00));
        chk("rst_last",  128'(odata_last), 128'(1'b0));
        chk("rst_ovf",   128'(ovf_err), 128'(1'b0));
        rstn = 1'b1;
        tick();

        // Full row of 8, consumer always ready
        odata_ready = 1'b1;
        cfg_row_len = 8'd8;
        for (int i = 1; i <= 7; i++) send(8'(i));
        chk("full_early_valid", 128'(odata_valid), 128'(1'b0));
        send(8'h08);
        chk("full_valid", 128'(odata_valid), 128'(1'b1));
        chk("full_data",  128'(odata), 128'(64'h0807060504030201));
        chk("full_mask",  128'(odata_mask), 128'(8'hFF));
        chk("full_last",  128'(odata_last), 128'(1'b1));
        tick();
        chk("full_popped", 128'(odata_valid), 128'(1'b0));
        odata_ready = 1'b0;

        // Row of 10: full word then 2-lane tail
        cfg_row_len = 8'd10;
        for (int i = 1; i <= 8; i++) send(8'(i));
        chk("part_w1_valid", 128'(odata_valid), 128'(1'b1));
        chk("part_w1_data",  128'(odata), 128'(64'h0807060504030201));
        chk("part_w1_mask",  128'(odata_mask), 128'(8'hFF));
        chk("part_w1_last",  128'(odata_last), 128'(1'b0));
        send(8'h09);
        send(8'h0A);
        chk("part_hold_data", 128'(odata), 128'(64'h0807060504030201));
        chk("part_hold_last", 128'(odata_last), 128'(1'b0));
        pop();
        chk("part_w2_valid", 128'(odata_valid), 128'(1'b1));
        chk("part_w2_data",  128'(odata), 128'(64'h0000000000000A09));
        chk("part_w2_mask",  128'(odata_mask), 128'(8'h03));
        chk("part_w2_last",  128'(odata_last), 128'(1'b1));
        pop();
        chk("part_empty", 128'(odata_valid), 128'(1'b0));

        // Overflow: 5 rows, no consumer; clear asserted together with the drop
        cfg_row_len = 8'd8;
        for (int r = 1; r <= 4; r++) begin
            for (int i = 1; i <= 8; i++) send(8'((r * 16) + i));
        end
        chk("ovf_before", 128'(ovf_err), 128'(1'b0));
        for (int i = 1; i <= 7; i++) send(8'(80 + i));
        clr_err = 1'b1;
        send(8'h58);
        clr_err = 1'b0;
        chk("ovf_set_wins", 128'(ovf_err), 128'(1'b1));
        tick();
        chk("ovf_sticky", 128'(ovf_err), 128'(1'b1));
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ovf_cleared", 128'(ovf_err), 128'(1'b0));
        chk("ovf_head_row1", 128'(odata), 128'(row_word(1)));
        // Row 6 completes while full with a simultaneous pop: must be kept
        for (int i = 1; i <= 7; i++) send(8'(96 + i));
        odata_ready = 1'b1;
        send(8'h68);
        odata_ready = 1'b0;
        chk("pushpop_no_ovf", 128'(ovf_err), 128'(1'b0));
        chk("drain_row2", 128'(odata), 128'(row_word(2)));
        pop();
        chk("drain_row3", 128'(odata), 128'(row_word(3)));
        pop();
        chk("drain_row4", 128'(odata), 128'(row_word(4)));
        chk("drain_row4_last", 128'(odata_last), 128'(1'b1));
        pop();
        chk("drain_row6", 128'(odata), 128'(row_word(6)));
        pop();
        chk("drain_empty", 128'(odata_valid), 128'(1'b0));

        // Reset in the middle of a row
        odata_ready = 1'b1;
        send(8'hA1);
        send(8'hA2);
        send(8'hA3);
        rstn = 1'b0;
        #2;
        chk("midrst_valid", 128'(odata_valid), 128'(1'b0));
        rstn = 1'b1;
        for (int i = 1; i <= 7; i++) send(8'(8'hB0 + i));
        chk("midrst_early", 128'(odata_valid), 128'(1'b0));
        send(8'hB8);
        chk("midrst_valid2", 128'(odata_valid), 128'(1'b1));
        chk("midrst_data",   128'(odata), 128'(64'hB8B7B6B5B4B3B2B1));
        chk("midrst_mask",   128'(odata_mask), 128'(8'hFF));
        tick();
        chk("midrst_one_word", 128'(odata_valid), 128'(1'b0));
        odata_ready = 1'b0;

        // Zero row length behaves as length 1
        cfg_row_len = 8'd0;
        send(8'h55);
        send(8'h66);
        send(8'h77);
        chk("zero_w1_data", 128'(odata), 128'(64'h55));
        chk("zero_w1_mask", 128'(odata_mask), 128'(8'h01));
        chk("zero_w1_last", 128'(odata_last), 128'(1'b1));
        pop();
        chk("zero_w2_data", 128'(odata), 128'(64'h66));
        chk("zero_w2_mask", 128'(odata_mask), 128'(8'h01));
        pop();
        chk("zero_w3_data", 128'(odata), 128'(64'h77));
        chk("zero_w3_last", 128'(odata_last), 128'(1'b1));
        pop();
        chk("zero_empty", 128'(odata_valid), 128'(1'b0));

        // Row sum with the FIFO full (4 fill rows of -1, then 7F,80,01,02)
        cfg_row_len = 8'd4;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) send(8'hFF);
`ifdef CONSMAX_PACK_SUM_EN
            if (r == 0) begin
                chk("sum_neg_valid", 128'(row_sum_valid), 128'(1'b1));
                chk("sum_neg",       128'(row_sum), 128'(16'hFFFC));
            end
`endif
        end
        send(8'h7F);
        send(8'h80);
        send(8'h01);
        send(8'h02);
        chk("sum_row_dropped", 128'(ovf_err), 128'(1'b1));
`ifdef CONSMAX_PACK_SUM_EN
        chk("sum_valid_pulse", 128'(row_sum_valid), 128'(1'b1));
        chk("sum_value",       128'(row_sum), 128'(16'h0002));
        tick();
        chk("sum_valid_drop",  128'(row_sum_valid), 128'(1'b0));
        chk("sum_hold",        128'(row_sum), 128'(16'h0002));
`endif
        chk("sum_fifo_head", 128'(odata_mask), 128'(8'h0F));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
